schmidl_cox_preamble_inserter: RTL and testbench



---
 rtl/schmidl_cox_preamble_inserter.sv | 173 +++++++++++++++++
 tb/tb_schmidl_cox_preamble_inserter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/schmidl_cox_preamble_inserter.sv
`timescale 1ns/1ps
// Schmidl-Cox transmit framer: emits CP + A + A from a small half-symbol RAM,
// then exactly payload_len payload samples, with tlast on the final sample.
module schmidl_cox_preamble_inserter #(
   parameter int ITEM_W   = 32,
   parameter int HALF_LEN = 8,
   parameter int CP_LEN   = 8,
   parameter int LEN_W    = 16
) (
   input  logic                        ce_clk,
   input  logic                        ce_rst_n,
   input  logic                        enable,
   input  logic [LEN_W-1:0]            payload_len,
   input  logic                        pre_wr_en,
   input  logic [$clog2(HALF_LEN)-1:0] pre_wr_addr,
   input  logic [ITEM_W-1:0]           pre_wr_data,
   input  logic [ITEM_W-1:0]           s_axis_tdata,
   input  logic                        s_axis_tlast,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic [ITEM_W-1:0]           m_axis_tdata,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        busy,
   output logic                        err_short,
   output logic [15:0]                 frame_count
);

   localparam int AW = $clog2(HALF_LEN);
   localparam logic [AW-1:0] CP_START = AW'(HALF_LEN - CP_LEN);
   localparam logic [AW-1:0] LAST_IDX = AW'(HALF_LEN - 1);

   if (CP_LEN > HALF_LEN || CP_LEN == 0 || HALF_LEN < 2) begin : g_param_check
      $error("schmidl_cox_preamble_inserter: CP_LEN must be 1..HALF_LEN and HALF_LEN >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_CP, S_HALF1, S_HALF2, S_PAYLOAD, S_PAD, S_DRAIN
   } state_t;

   state_t            r_state;
   logic [ITEM_W-1:0] r_ram [HALF_LEN];
   logic [AW-1:0]     r_idx;
   logic [LEN_W-1:0]  r_cnt;
   logic [LEN_W-1:0]  r_len;
   logic [ITEM_W-1:0] r_m_tdata;
   logic              r_m_tlast;
   logic              r_m_tvalid;
   logic              r_busy;
   logic              r_err_short;
   logic [15:0]       r_frame_count;

   logic              w_load;
   logic              w_start;
   logic              w_in_hs;
   logic              w_seg_end;
   logic [LEN_W-1:0]  w_cnt_inc;
   logic              w_cnt_done;

   assign w_load        = !r_m_tvalid || m_axis_tready;
   assign w_start       = (r_state == S_IDLE) && enable && s_axis_tvalid;
   assign s_axis_tready = (r_state == S_PAYLOAD) && w_load;
   assign w_in_hs       = s_axis_tvalid && s_axis_tready;
   assign w_seg_end     = (r_idx == LAST_IDX);
   assign w_cnt_inc     = r_cnt + 1'b1;
   assign w_cnt_done    = (w_cnt_inc == r_len);

   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tlast  = r_m_tlast;
   assign m_axis_tvalid = r_m_tvalid;
   assign busy          = r_busy;
   assign err_short     = r_err_short;
   assign frame_count   = r_frame_count;

   // NOTE: every register here uses <= so all state updates see the same pre-edge values.
   always_ff @(posedge ce_clk or negedge ce_rst_n) begin
      if (!ce_rst_n) begin
         r_state       <= S_IDLE;
         r_idx         <= CP_START;
         r_cnt         <= '0;
         r_len         <= '0;
         r_m_tdata     <= '0;
         r_m_tlast     <= 1'b0;
         r_m_tvalid    <= 1'b0;
         r_busy        <= 1'b0;
         r_err_short   <= 1'b0;
         r_frame_count <= '0;
         // NOTE: the RAM is reset so a frame sent before any load is all-zero, not X.
         for (int i = 0; i < HALF_LEN; i++) r_ram[i] <= '0;
      end else begin
         r_err_short <= 1'b0;

         if (pre_wr_en && !r_busy && (32'(pre_wr_addr) < HALF_LEN))
            r_ram[pre_wr_addr] <= pre_wr_data;

         case (r_state)
            // The first CP sample is loaded on the detect edge so it is valid one cycle later.
            S_IDLE, S_CP: begin
               if (w_start || (r_state == S_CP && w_load)) begin
                  if (r_state == S_IDLE) begin
                     r_len  <= payload_len;
                     r_cnt  <= '0;
                     r_busy <= 1'b1;
                  end
                  r_m_tvalid <= 1'b1;
                  r_m_tdata  <= r_ram[r_idx];
                  r_state    <= w_seg_end ? S_HALF1 : S_CP;
                  r_idx      <= w_seg_end ? '0 : r_idx + 1'b1;
               end
            end
            S_HALF1, S_HALF2: begin
               if (w_load) begin
                  r_m_tvalid <= 1'b1;
                  r_m_tdata  <= r_ram[r_idx];
                  if (!w_seg_end) begin
                     r_idx <= r_idx + 1'b1;
                  end else if (r_state == S_HALF1) begin
                     r_idx   <= '0;
                     r_state <= S_HALF2;
                  end else begin
                     r_idx <= CP_START;
                     if (r_len == '0) begin
                        r_m_tlast <= 1'b1;
                        r_state   <= S_DRAIN;
                     end else begin
                        r_state <= S_PAYLOAD;
                     end
                  end
               end
            end
            S_PAYLOAD: begin
               if (w_load) begin
                  r_m_tvalid <= w_in_hs;
                  if (w_in_hs) begin
                     r_m_tdata <= s_axis_tdata;
                     r_cnt     <= w_cnt_inc;
                     if (w_cnt_done) begin
                        r_m_tlast <= 1'b1;
                        r_state   <= S_DRAIN;
                     end else if (s_axis_tlast) begin
                        r_err_short <= 1'b1;
                        r_state     <= S_PAD;
                     end
                  end
               end
            end
            S_PAD: begin
               if (w_load) begin
                  r_m_tvalid <= 1'b1;
                  r_m_tdata  <= '0;
                  r_cnt      <= w_cnt_inc;
                  if (w_cnt_done) begin
                     r_m_tlast <= 1'b1;
                     r_state   <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (m_axis_tready) begin
                  r_m_tvalid    <= 1'b0;
                  r_m_tlast     <= 1'b0;
                  r_busy        <= 1'b0;
                  r_frame_count <= r_frame_count + 1'b1;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
`timescale 1ns/1ps
// Scoreboard bench: each frame's expected beats come from a list-level model
// (CP tail of A, A, A, payload padded to length); a monitor pops and compares.
module tb_schmidl_cox_preamble_inserter;

   localparam int ITEM_W   = 32;
   localparam int HALF_LEN = 8;
   localparam int CP_LEN   = 8;
   localparam int LEN_W    = 16;
   localparam int AW       = $clog2(HALF_LEN);

   typedef struct {
      logic [ITEM_W-1:0] data;
      logic              last;
   } beat_t;

   logic              ce_clk = 1'b0;
   logic              ce_rst_n;
   logic              enable;
   logic [LEN_W-1:0]  payload_len;
   logic              pre_wr_en;
   logic [AW-1:0]     pre_wr_addr;
   logic [ITEM_W-1:0] pre_wr_data;
   logic [ITEM_W-1:0] s_axis_tdata;
   logic              s_axis_tlast;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [ITEM_W-1:0] m_axis_tdata;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              busy;
   logic              err_short;
   logic [15:0]       frame_count;

   always #5 ce_clk = ~ce_clk;

   schmidl_cox_preamble_inserter #(
      .ITEM_W(ITEM_W), .HALF_LEN(HALF_LEN), .CP_LEN(CP_LEN), .LEN_W(LEN_W)
   ) dut (
      .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .enable(enable), .payload_len(payload_len),
      .pre_wr_en(pre_wr_en), .pre_wr_addr(pre_wr_addr), .pre_wr_data(pre_wr_data),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .busy(busy), .err_short(err_short), .frame_count(frame_count)
   );

   int checks   = 0;
   int failures = 0;

   beat_t             exp_q[$];
   beat_t             src_q[$];
   logic [ITEM_W-1:0] model_a [HALF_LEN];
   int                model_frames  = 0;
   int                exp_err       = 0;
   int                src_stall     = 0;
   int                snk_stall     = 0;
   int                mon_beats     = 0;
   int                err_pulses    = 0;
   int                sready_cycles = 0;
   int                sready_base   = 0;
   int                cur_len       = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Source: presents queued beats, random idle gaps, holds each beat until accepted.
   initial begin
      bit in_hs;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      forever begin
         @(negedge ce_clk);
         in_hs = s_axis_tvalid && s_axis_tready;
         @(posedge ce_clk);
         #1;
         if (in_hs && src_q.size() > 0) void'(src_q.pop_front());
         if (in_hs || src_q.size() == 0) s_axis_tvalid = 1'b0;
         if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(0, 99) >= src_stall) begin
            s_axis_tdata  = src_q[0].data;
            s_axis_tlast  = src_q[0].last;
            s_axis_tvalid = 1'b1;
         end
      end
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge ce_clk);
         #1;
         m_axis_tready = ($urandom_range(0, 99) >= snk_stall);
      end
   end

   // Monitor: compares every output handshake against the scoreboard and checks hold stability.
   initial begin
      beat_t             e;
      bit                held = 1'b0;
      logic [ITEM_W-1:0] held_data = '0;
      logic              held_last = 1'b0;
      forever begin
         @(negedge ce_clk);
         if (!ce_rst_n) begin
            held = 1'b0;
         end else begin
            if (s_axis_tready) sready_cycles++;
            if (err_short) err_pulses++;
            if (held)
               check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                     {1'b1, held_last, held_data});
            held      = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
               mon_beats++;
               check("beat_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("beat_data", m_axis_tdata, e.data);
                  check("beat_last", m_axis_tlast, e.last);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached before the test sequence completed");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic write_ram(input int addr, input logic [ITEM_W-1:0] data, input bit taken);
      @(posedge ce_clk);
      #1;
      pre_wr_en   = 1'b1;
      pre_wr_addr = AW'(addr);
      pre_wr_data = data;
      @(posedge ce_clk);
      #1;
      pre_wr_en = 1'b0;
      if (taken) model_a[addr] = data;
   endtask

   // tlast_at: 1-based input sample carrying tlast, 0 for none.
   task automatic start_frame(input int len, input logic [ITEM_W-1:0] base, input int tlast_at);
      int    nsamp;
      int    total;
      int    k;
      int    cyc;
      beat_t b;
      cur_len     = len;
      sready_base = sready_cycles;
      nsamp = (len == 0) ? 1 : ((tlast_at > 0 && tlast_at < len) ? tlast_at : len);
      total = CP_LEN + 2 * HALF_LEN + len;
      k = 0;
      for (int i = 0; i < CP_LEN; i++) begin
         b.data = model_a[HALF_LEN - CP_LEN + i]; b.last = (k == total - 1); exp_q.push_back(b); k++;
      end
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < HALF_LEN; i++) begin
            b.data = model_a[i]; b.last = (k == total - 1); exp_q.push_back(b); k++;
         end
      for (int i = 0; i < len; i++) begin
         b.data = (i < nsamp) ? base + ITEM_W'(i) : '0;
         b.last = (k == total - 1);
         exp_q.push_back(b);
         k++;
      end
      if (tlast_at > 0 && tlast_at < len) exp_err++;
      for (int i = 0; i < nsamp; i++) begin
         b.data = base + ITEM_W'(i); b.last = ((i + 1) == tlast_at); src_q.push_back(b);
      end
      payload_len = LEN_W'(len);
      enable      = 1'b1;
      for (cyc = 0; cyc < 500 && !busy; cyc++) @(negedge ce_clk);
      check("frame_started", busy, 1);
      enable = 1'b0;
   endtask

   // exp_cycles > 0 also checks the number of cycles busy stays high (gapless framing).
   task automatic finish_frame(input int exp_cycles);
      int cyc;
      for (cyc = 0; cyc < 3000 && busy; cyc++) @(negedge ce_clk);
      check("frame_ended", busy, 0);
      if (exp_cycles > 0) check("busy_cycles", cyc, exp_cycles);
      model_frames++;
      check("scoreboard_drained", exp_q.size(), 0);
      check("frame_count", frame_count, model_frames);
      check("err_short_pulses", err_pulses, exp_err);
      if (cur_len == 0) begin
         check("s_tready_never_high", sready_cycles - sready_base, 0);
         src_q.delete();
      end
      repeat (2) @(posedge ce_clk);
   endtask

   initial begin
      logic [ITEM_W-1:0] base;
      int                b0;
      int                cyc;
      int                len;
      int                tl;
      int                mode;
      ce_rst_n    = 1'b0;
      enable      = 1'b0;
      payload_len = '0;
      pre_wr_en   = 1'b0;
      pre_wr_addr = '0;
      pre_wr_data = '0;
      for (int i = 0; i < HALF_LEN; i++) model_a[i] = '0;
      repeat (3) @(posedge ce_clk);
      #1;
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_m_tdata", m_axis_tdata, 0);
      check("rst_m_tlast", m_axis_tlast, 0);
      check("rst_s_tready", s_axis_tready, 0);
      check("rst_busy", busy, 0);
      check("rst_err_short", err_short, 0);
      check("rst_frame_count", frame_count, 0);
      @(negedge ce_clk);
      ce_rst_n = 1'b1;

      for (int i = 0; i < HALF_LEN; i++) write_ram(i, 32'h0001_0000 + ITEM_W'(i), 1'b1);

      base = $urandom();
      start_frame(16, base, 16);
      finish_frame(40);

      src_stall = 25;
      snk_stall = 25;
      start_frame(16, base, 16);
      finish_frame(0);
      src_stall = 0;
      snk_stall = 0;

      start_frame(16, $urandom(), 10);
      finish_frame(40);

      start_frame(0, $urandom(), 0);
      finish_frame(24);

      start_frame(4, $urandom(), 4);
      write_ram(3, 32'hDEAD_BEEF, 1'b0);
      finish_frame(0);
      start_frame(4, $urandom(), 4);
      finish_frame(28);
      write_ram(3, 32'hDEAD_BEEF, 1'b1);
      start_frame(4, $urandom(), 4);
      finish_frame(28);

      start_frame(5, $urandom(), 0);
      finish_frame(29);

      for (int f = 0; f < 8; f++) begin
         write_ram($urandom_range(0, HALF_LEN - 1), $urandom(), 1'b1);
         len  = $urandom_range(0, 20);
         mode = $urandom_range(0, 2);
         if (len == 0)                  tl = 0;
         else if (mode == 0)            tl = len;
         else if (mode == 1)            tl = 0;
         else if (len >= 2)             tl = $urandom_range(1, len - 1);
         else                           tl = len;
         src_stall = $urandom_range(0, 40);
         snk_stall = $urandom_range(0, 40);
         start_frame(len, $urandom(), tl);
         finish_frame(0);
      end
      src_stall = 0;
      snk_stall = 0;

      b0 = mon_beats;
      start_frame(16, $urandom(), 16);
      for (cyc = 0; cyc < 200 && (mon_beats - b0) < 12; cyc++) @(posedge ce_clk);
      check("reached_beat_12", (mon_beats - b0) >= 12, 1);
      #2;
      ce_rst_n = 1'b0;
      #1;
      check("midrst_m_tvalid", m_axis_tvalid, 0);
      check("midrst_m_tdata", m_axis_tdata, 0);
      check("midrst_m_tlast", m_axis_tlast, 0);
      check("midrst_busy", busy, 0);
      check("midrst_frame_count", frame_count, 0);
      exp_q.delete();
      src_q.delete();
      model_frames = 0;
      for (int i = 0; i < HALF_LEN; i++) model_a[i] = '0;
      repeat (3) @(posedge ce_clk);
      @(negedge ce_clk);
      ce_rst_n = 1'b1;
      @(negedge ce_clk);
      check("postrst_frame_count", frame_count, 0);
      check("postrst_s_tready", s_axis_tready, 0);
      start_frame(4, $urandom(), 4);
      finish_frame(28);
      for (int i = 0; i < HALF_LEN; i++) write_ram(i, $urandom(), 1'b1);
      start_frame(6, $urandom(), 6);
      finish_frame(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
